rect_raster: RTL and testbench

Parametrised rectangle rasteriser, successor to the fixed 8-bit rectangle engine. Latches a rectangle command, clips it to a configurable screen and emits only the pixels to be drawn, in raster order, on a valid/ready stream. Supports filled mode and outline mode with programmable border thickness. Interior pixels are skipped in zero cycles. Sits between the shape command decoder and the framebuffer write arbiter.

---
 rtl/rect_raster_if.sv | 38 +++
 rtl/rect_raster.sv | 161 ++++++++++++++++
 tb/tb_rect_raster.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_raster_if.sv
// Command and pixel-stream bundle for the rectangle rasteriser.
// master: command decoder / pixel sink side; slave: the rasteriser itself.
interface rect_raster_if #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned COLOR_W = 24,
  parameter int unsigned THICK_W = 4
);
  // Command side
  logic               start;
  logic               abort;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               fill_enable;
  logic [THICK_W-1:0] thick;
  logic [COLOR_W-1:0] color;

  // Pixel stream and status
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic [COLOR_W-1:0] pixel_color;
  logic               pixel_valid;
  logic               pixel_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, abort, x0, y0, x1, y1, fill_enable, thick, color, pixel_ready,
    input  px, py, pixel_color, pixel_valid, busy, done, err
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, fill_enable, thick, color, pixel_ready,
    output px, py, pixel_color, pixel_valid, busy, done, err
  );
endinterface

// File: rtl/rect_raster.sv
// Rectangle rasteriser: latches a command, clips it to the screen and streams
// the pixels to draw (filled or outlined) in raster order on valid/ready.
module rect_raster #(
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned COLOR_W  = 24,
  parameter int unsigned SCREEN_W = 256,
  parameter int unsigned SCREEN_H = 256,
  parameter int unsigned THICK_W  = 4
) (
  input logic          clk,
  input logic          rst_n,
  rect_raster_if.slave bus
);

  // Wide enough that coord + thickness never wraps.
  localparam int unsigned W = COORD_W + THICK_W + 1;
  typedef logic [W-1:0] wide_t;

  localparam wide_t XMax = wide_t'(SCREEN_W - 1);
  localparam wide_t YMax = wide_t'(SCREEN_H - 1);
  localparam wide_t One  = wide_t'(1);

  typedef enum logic [1:0] {StIdle, StSetup, StDraw, StFinish} state_e;

  state_e state_q;

  // Latched command
  wide_t              x0_q, y0_q, x1_q, y1_q, t_q;
  wide_t              cx1_q, cy1_q;
  logic               fill_q;
  logic [COLOR_W-1:0] color_q;

  // Registered outputs; px_q/py_q double as the draw cursor
  logic [COORD_W-1:0] px_q, py_q;
  logic [COLOR_W-1:0] pcol_q;
  logic               valid_q, busy_q, done_q, err_q;

  wide_t cur_x, cur_y, inc_x, nxt_x, nxt_y;
  logic  row_border, col_border, new_row, last_pix;

  // Next emitted pixel after the current cursor, skipping outline interiors.
  always_comb begin
    cur_x      = wide_t'(px_q);
    cur_y      = wide_t'(py_q);
    inc_x      = cur_x + One;
    row_border = (cur_y < y0_q + t_q) || (cur_y + t_q > y1_q);
    col_border = (inc_x < x0_q + t_q) || (inc_x + t_q > x1_q);
    nxt_x      = inc_x;
    // Entering the interior of a non-border row: jump to the right border.
    if (!fill_q && !row_border && !col_border) begin
      nxt_x = x1_q - t_q + One;
    end
    nxt_y    = cur_y + One;
    new_row  = nxt_x > cx1_q;
    last_pix = new_row && (nxt_y > cy1_q);
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      t_q     <= One;
      cx1_q   <= '0;
      cy1_q   <= '0;
      fill_q  <= 1'b0;
      color_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pcol_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        px_q    <= '0;
        py_q    <= '0;
        pcol_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              x0_q    <= wide_t'(bus.x0);
              y0_q    <= wide_t'(bus.y0);
              x1_q    <= wide_t'(bus.x1);
              y1_q    <= wide_t'(bus.y1);
              t_q     <= (bus.thick == '0) ? One : wide_t'(bus.thick);
              fill_q  <= bus.fill_enable;
              color_q <= bus.color;
              if ((bus.x1 < bus.x0) || (bus.y1 < bus.y0)) begin
                state_q <= StFinish;
                err_q   <= 1'b1;
              end else begin
                state_q <= StSetup;
                busy_q  <= 1'b1;
              end
            end
          end
          StSetup: begin
            cx1_q <= (x1_q > XMax) ? XMax : x1_q;
            cy1_q <= (y1_q > YMax) ? YMax : y1_q;
            if ((x0_q > XMax) || (y0_q > YMax)) begin
              // Fully off-screen: completes normally with nothing drawn.
              state_q <= StFinish;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StDraw;
              valid_q <= 1'b1;
              px_q    <= x0_q[COORD_W-1:0];
              py_q    <= y0_q[COORD_W-1:0];
              pcol_q  <= color_q;
            end
          end
          StDraw: begin
            if (valid_q && bus.pixel_ready) begin
              if (last_pix) begin
                state_q <= StFinish;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                px_q    <= '0;
                py_q    <= '0;
                pcol_q  <= '0;
              end else if (new_row) begin
                px_q <= x0_q[COORD_W-1:0];
                py_q <= nxt_y[COORD_W-1:0];
              end else begin
                px_q <= nxt_x[COORD_W-1:0];
              end
            end
          end
          StFinish: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.px          = px_q;
  assign bus.py          = py_q;
  assign bus.pixel_color = pcol_q;
  assign bus.pixel_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_rect_raster.sv
// Scoreboard bench for rect_raster on a 16x16 screen: a reference model pushes
// expected pixels at command issue, the monitor pops them on every transfer.
module tb_rect_raster;
  localparam int unsigned CW = 8;
  localparam int unsigned KW = 24;
  localparam int unsigned TW = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned SH = 16;

  typedef logic [63:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rect_raster_if #(.COORD_W(CW), .COLOR_W(KW), .THICK_W(TW)) bus ();

  rect_raster #(
    .COORD_W (CW),
    .COLOR_W (KW),
    .SCREEN_W(SW),
    .SCREEN_H(SH),
    .THICK_W (TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor state
  word_t       exp_q[$];
  int          cyc = 0;
  int          first_cyc, last_cyc, done_cyc;
  int          beat_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          mon_en = 1'b0;
  bit          stalled = 1'b0;
  word_t       held;
  int          rdy_mode = 0;
  int          pat_i = 0;
  logic [7:0]  rdy_pat = 8'b1111_0100;  // ready per valid cycle: 0,0,1,0,1,1..

  function automatic word_t pix(input int x, input int y, input logic [KW-1:0] c);
    return word_t'({1'b1, 8'(y), 8'(x), c});
  endfunction

  // Reference model: walks the clipped box and keeps fill or border pixels.
  function automatic int model(input int ax0, input int ay0, input int ax1, input int ay1,
                               input bit afill, input int athick, input logic [KW-1:0] acol,
                               input int limit, output bit is_err);
    int t, n;
    n = 0;
    t = (athick == 0) ? 1 : athick;
    is_err = (ax1 < ax0) || (ay1 < ay0);
    if (!is_err) begin
      for (int y = ay0; y <= ay1 && y < int'(SH); y++) begin
        for (int x = ax0; x <= ax1 && x < int'(SW); x++) begin
          if (afill || x < ax0 + t || x > ax1 - t || y < ay0 + t || y > ay1 - t) begin
            if (n < limit) exp_q.push_back(pix(x, y, acol));
            n++;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: always-on, fixed pattern while valid, or random.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      if (bus.pixel_valid) begin
        bus.pixel_ready = rdy_pat[pat_i[2:0]];
        if (pat_i < 7) pat_i++;
      end else begin
        bus.pixel_ready = 1'b0;
      end
    end else if (rdy_mode == 2) begin
      bus.pixel_ready = 1'($urandom_range(0, 1));
    end else begin
      bus.pixel_ready = 1'b1;
    end
  end

  // Monitor: counts pulses, checks transfers against the scoreboard.
  always @(negedge clk) begin : mon
    word_t cur;
    cur = word_t'({bus.pixel_valid, bus.py, bus.px, bus.pixel_color});
    if (mon_en) begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.err) err_cnt++;
      if (stalled) check("hold", cur, held);
      if (bus.pixel_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.pixel_ready) begin
          beat_cnt++;
          last_cyc = cyc;
          check("beat_expected", word_t'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("pixel", cur, exp_q.pop_front());
        end
      end else begin
        check("idle_zero", cur, 0);
      end
      stalled = bus.pixel_valid && !bus.pixel_ready;
      held    = cur;
    end
  end

  task automatic drive_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input bit afill, input int athick, input logic [KW-1:0] acol);
    bus.x0          = CW'(ax0);
    bus.y0          = CW'(ay0);
    bus.x1          = CW'(ax1);
    bus.y1          = CW'(ay1);
    bus.fill_enable = afill;
    bus.thick       = TW'(athick);
    bus.color       = acol;
  endtask

  task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                         input bit afill, input int athick, input logic [KW-1:0] acol,
                         input int rmode, input bit timing);
    int n, d0, e0, start_cyc;
    bit is_err;
    exp_q.delete();
    n = model(ax0, ay0, ax1, ay1, afill, athick, acol, 1000, is_err);
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
    beat_cnt  = 0;
    d0        = done_cnt;
    e0        = err_cnt;
    pat_i     = 0;
    rdy_mode  = rmode;
    drive_cmd(ax0, ay0, ax1, ay1, afill, athick, acol);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", word_t'(bus.busy), word_t'(!is_err));
    for (int i = 0; i < 400 && done_cnt == d0 && err_cnt == e0; i++) @(posedge clk);
    check("completed", word_t'(done_cnt != d0 || err_cnt != e0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("done_cnt", word_t'(done_cnt - d0), word_t'(!is_err));
    check("err_cnt", word_t'(err_cnt - e0), word_t'(is_err));
    check("beats", word_t'(beat_cnt), word_t'(n));
    check("leftover", word_t'(exp_q.size()), 0);
    if (rmode == 0 && n > 0) check("no_bubble", word_t'(last_cyc - first_cyc + 1), word_t'(n));
    if (timing && n > 0) begin
      check("first_latency", word_t'(first_cyc - start_cyc), 2);
      check("done_latency", word_t'(done_cyc - last_cyc), 1);
    end
    rdy_mode = 0;
    exp_q.delete();
  endtask

  initial begin
    int n, d0;
    bit is_err;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_cmd(0, 0, 0, 0, 1'b1, 0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", word_t'({bus.pixel_valid, bus.py, bus.px, bus.pixel_color}), 0);
    check("reset_flags", word_t'({bus.busy, bus.done, bus.err}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);

    // Filled, outline variants, clipping, rejection, single pixel, overflow edge
    run_cmd(2, 3, 4, 4, 1'b1, 1, 24'hA1B2C3, 0, 1'b1);
    run_cmd(0, 0, 3, 3, 1'b0, 1, 24'h00FF00, 0, 1'b1);
    run_cmd(0, 0, 3, 3, 1'b0, 2, 24'h0000FF, 0, 1'b0);
    run_cmd(0, 0, 3, 3, 1'b0, 0, 24'h123456, 0, 1'b0);
    run_cmd(3, 5, 4, 5, 1'b1, 1, 24'hCAFE01, 1, 1'b0);
    run_cmd(14, 0, 20, 0, 1'b0, 1, 24'h777777, 0, 1'b0);
    run_cmd(16, 0, 20, 0, 1'b1, 1, 24'h777777, 0, 1'b0);
    run_cmd(5, 0, 4, 0, 1'b1, 1, 24'h111111, 0, 1'b0);
    run_cmd(7, 7, 7, 7, 1'b0, 3, 24'hFEDCBA, 0, 1'b1);
    run_cmd(13, 13, 255, 255, 1'b0, 1, 24'h0F0F0F, 0, 1'b0);
    run_cmd(2, 1, 11, 9, 1'b0, 3, 24'h5A5A5A, 2, 1'b0);

    // start held through a command, inputs changed mid-run, restart after done
    exp_q.delete();
    n = model(1, 1, 2, 2, 1'b1, 1, 24'hAAAA01, 1000, is_err);
    n = model(3, 5, 4, 5, 1'b1, 1, 24'hBBBB02, 1000, is_err);
    beat_cnt = 0;
    d0 = done_cnt;
    drive_cmd(1, 1, 2, 2, 1'b1, 1, 24'hAAAA01);
    bus.start = 1'b1;
    for (int i = 0; i < 100 && beat_cnt < 1; i++) @(posedge clk);
    #1 drive_cmd(3, 5, 4, 5, 1'b1, 1, 24'hBBBB02);
    for (int i = 0; i < 100 && done_cnt < d0 + 1; i++) @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("restart_busy", word_t'(bus.busy), 1);
    for (int i = 0; i < 100 && done_cnt < d0 + 2; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("restart_dones", word_t'(done_cnt - d0), 2);
    check("restart_beats", word_t'(beat_cnt), 6);
    check("restart_left", word_t'(exp_q.size()), 0);
    exp_q.delete();

    // Abort after 3 accepted beats; the beat in the abort cycle still transfers
    n = model(0, 0, 3, 3, 1'b1, 1, 24'hABCDEF, 4, is_err);
    beat_cnt = 0;
    d0 = done_cnt;
    drive_cmd(0, 0, 3, 3, 1'b1, 1, 24'hABCDEF);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 100 && beat_cnt < 3; i++) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_valid", word_t'(bus.pixel_valid), 0);
    check("abort_busy", word_t'(bus.busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", word_t'(done_cnt - d0), 0);
    check("abort_beats", word_t'(beat_cnt), 4);
    check("abort_left", word_t'(exp_q.size()), 0);
    exp_q.delete();

    // Reset mid-draw, with start asserted at the reset edge
    n = model(0, 0, 3, 3, 1'b1, 1, 24'h135790, 1000, is_err);
    beat_cnt = 0;
    drive_cmd(0, 0, 3, 3, 1'b1, 1, 24'h135790);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 100 && beat_cnt < 2; i++) @(posedge clk);
    #1;
    mon_en    = 1'b0;
    stalled   = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", word_t'({bus.pixel_valid, bus.py, bus.px, bus.pixel_color}), 0);
    check("rst_flags", word_t'({bus.busy, bus.done, bus.err}), 0);
    @(negedge clk);
    check("rst_no_start", word_t'({bus.pixel_valid, bus.busy}), 0);
    exp_q.delete();
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Normal operation resumes after reset
    run_cmd(6, 2, 8, 3, 1'b1, 1, 24'h2468AC, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
